write_data_packer: RTL and testbench
====================================

Name: write_data_packer

Overview:
- Upstream neighbour of the write data FIFO.
- Accepts frontend write-data beats of `FRONTEND_WORD_SIZE` bits over a valid/ready handshake.
- Packs BEATS consecutive beats into one backend word of `BACKEND_WORD_SIZE` bits and pushes it into the FIFO, honouring the FIFO full flag.
- Double-buffered (assembly register + output register), so a full-rate beat stream sustains 1 beat/cycle while the FIFO has space.

Parameters:
- FE_WIDTH, `FRONTEND_WORD_SIZE` (256): width of one frontend beat.
- BEATS, 4: beats per backend word; power of two, >= 2.
- BE_WIDTH, FE_WIDTH*BEATS (1024, = `BACKEND_WORD_SIZE`): packed word width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_fe_valid  in  1  frontend beat valid.
- i_fe_data  in  FE_WIDTH  frontend beat data.
- o_fe_ready  out  1  packer can accept a beat this cycle.
- o_wr_en  out  1  push strobe to FIFO wr_en.
- o_wr_data  out  BE_WIDTH  packed word to FIFO i_data.
- i_fifo_full  in  1  FIFO o_full; registered in the FIFO, so no combinational loop.
- o_beat_cnt  out  $clog2(BEATS)  number of beats held in the assembly register.
- o_out_valid  out  1  output register holds an unpushed word.

Behaviour:
- Reset (async, i_rst_n=0):
  - beat counter = 0, assembly register = 0, output register = 0, out_valid = 0.
  - Outputs: o_wr_en=0, o_wr_data=0, o_beat_cnt=0, o_out_valid=0, o_fe_ready=1 once reset is released.
- Accept: a beat is accepted when i_fe_valid && o_fe_ready at the rising edge.
- Packing order: beat k (k = o_beat_cnt at acceptance) is written to assembly bits [k*FE_WIDTH +: FE_WIDTH]. Beat 0 is least significant.
- Non-last beat (cnt < BEATS-1): cnt increments by 1; the slice is stored.
- Last beat (cnt == BEATS-1):
  - Output register <= assembly with the top slice replaced by i_fe_data; out_valid <= 1.
  - cnt wraps to 0. The assembly register is not cleared (stale bits are overwritten before reuse).
- Push:
  - o_wr_en = out_valid && !i_fifo_full, combinational.
  - o_wr_data = output register, stable while out_valid.
  - On o_wr_en at an edge, out_valid <= 0 unless a new last beat loads the register in the same cycle; in that case out_valid stays 1 with the new word.
- Ready:
  - o_fe_ready = (cnt != BEATS-1) || !out_valid || !i_fifo_full.
  - Non-last beats are never stalled. The last beat stalls only while the output slot is occupied and cannot drain this cycle.
- Latency: last beat accepted at edge N -> o_wr_en may assert in cycle N+1.
- Throughput: with the FIFO never full, one word per BEATS cycles and no bubbles.
- Boundaries:
  - FIFO full for many cycles: the packer absorbs up to BEATS-1 further beats, then holds o_fe_ready=0 with out_valid=1 and o_wr_data stable.
  - i_fifo_full falling: the push and the acceptance of the stalled last beat occur on the same edge.
  - i_fe_valid=0 mid-word: the partial word is held indefinitely; no timeout.
  - o_wr_en never asserts when i_fifo_full=1, so the FIFO never sees a dropped write.
  - Reset mid-word: the partial word and any unpushed output word are discarded.

Optional Feature:
- Macro WRITE_PACKER_ABORT_EN.
- Defined: adds input port i_abort (1 bit, synchronous, active-high).
  - In a cycle with i_abort=1, o_fe_ready is forced to 0 and cnt <= 0 at the edge, discarding the partial word.
  - out_valid, the output register and the push logic are unaffected; a pending word still drains.
- Not defined: port absent; behaviour exactly as above.

Test Plan:
- Reset, then 4 back-to-back beats 0x11..,0x22..,0x33..,0x44.. with i_fifo_full=0 -> o_wr_en is a single-cycle pulse in the cycle after beat 4; o_wr_data = {0x44..,0x33..,0x22..,0x11..}; o_beat_cnt sequence 0,1,2,3,0.
- 16 continuous beats, i_fifo_full=0 -> exactly 4 o_wr_en pulses, spaced 4 cycles apart; o_fe_ready stays 1 throughout.
- i_fifo_full=1 held while streaming 12 beats -> first word held (o_out_valid=1, o_wr_en=0); beats 5-7 accepted; o_fe_ready=0 at cnt=3. Drop full -> push and 8th-beat acceptance on the same edge; second word pushed the next cycle.
- i_fe_valid gaps of random length between beats -> packed words identical to the gap-free case; no spurious o_wr_en.
- Assert reset after 2 beats and again while o_out_valid=1 -> all outputs return to 0 immediately; the next 4 beats form a clean word.
- (WRITE_PACKER_ABORT_EN) 3 beats, i_abort for 1 cycle, then 4 new beats -> exactly one word pushed, containing only the 4 new beats.

Source files
------------

// File: rtl/write_data_packer_if.sv
// Bus bundle between the frontend write-data source, the packer and the
// write data FIFO. The slave modport is the packer's view; the master
// modport is the view of whatever drives the beats and owns the FIFO flag.
// Optional macro: WRITE_PACKER_ABORT_EN adds the i_abort signal.

`ifndef FRONTEND_WORD_SIZE
`define FRONTEND_WORD_SIZE 256
`endif

interface write_data_packer_if #(
    parameter int FE_WIDTH = `FRONTEND_WORD_SIZE,
    parameter int BEATS    = 4,
    parameter int BE_WIDTH = FE_WIDTH * BEATS
);
    localparam int CNT_WIDTH = $clog2(BEATS);

    logic                 i_fe_valid;
    logic [FE_WIDTH-1:0]  i_fe_data;
    logic                 o_fe_ready;
    logic                 o_wr_en;
    logic [BE_WIDTH-1:0]  o_wr_data;
    logic                 i_fifo_full;
    logic [CNT_WIDTH-1:0] o_beat_cnt;
    logic                 o_out_valid;
`ifdef WRITE_PACKER_ABORT_EN
    logic                 i_abort;
`endif

`ifdef WRITE_PACKER_ABORT_EN
    modport slave (
        input  i_fe_valid, i_fe_data, i_fifo_full, i_abort,
        output o_fe_ready, o_wr_en, o_wr_data, o_beat_cnt, o_out_valid
    );

    modport master (
        output i_fe_valid, i_fe_data, i_fifo_full, i_abort,
        input  o_fe_ready, o_wr_en, o_wr_data, o_beat_cnt, o_out_valid
    );
`else
    modport slave (
        input  i_fe_valid, i_fe_data, i_fifo_full,
        output o_fe_ready, o_wr_en, o_wr_data, o_beat_cnt, o_out_valid
    );

    modport master (
        output i_fe_valid, i_fe_data, i_fifo_full,
        input  o_fe_ready, o_wr_en, o_wr_data, o_beat_cnt, o_out_valid
    );
`endif

endinterface

// File: rtl/write_data_packer.sv
// Write data packer: gathers BEATS frontend beats into one backend word and
// pushes it into the write data FIFO. An assembly register collects the beats
// while an output register holds the finished word until the FIFO takes it,
// so a continuous beat stream runs at one beat per cycle while the FIFO has
// room.
// Optional macro: WRITE_PACKER_ABORT_EN adds a synchronous i_abort that drops
// the partially assembled word without touching a pending output word.

`ifndef FRONTEND_WORD_SIZE
`define FRONTEND_WORD_SIZE 256
`endif

module write_data_packer #(
    parameter int FE_WIDTH = `FRONTEND_WORD_SIZE,
    parameter int BEATS    = 4,
    parameter int BE_WIDTH = FE_WIDTH * BEATS
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    write_data_packer_if.slave   bus
);

    localparam int                   CNT_WIDTH = $clog2(BEATS);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(BEATS - 1);
    localparam int                   TOP_LSB   = (BEATS - 1) * FE_WIDTH;

    logic [CNT_WIDTH-1:0] cnt;
    logic [BE_WIDTH-1:0]  asm_reg;
    logic [BE_WIDTH-1:0]  out_reg;
    logic                 out_valid;

    logic                 last_beat;
    logic                 push;
    logic                 fe_ready;
    logic                 accept;
    logic                 load_out;
    logic                 abort;
    logic [BE_WIDTH-1:0]  packed_word;

`ifdef WRITE_PACKER_ABORT_EN
    assign abort = bus.i_abort;
`else
    assign abort = 1'b0;
`endif

    assign last_beat = (cnt == LAST_CNT);
    assign push      = out_valid && !bus.i_fifo_full;
    assign fe_ready  = (!last_beat || !out_valid || !bus.i_fifo_full) && !abort;
    assign accept    = bus.i_fe_valid && fe_ready;
    assign load_out  = accept && last_beat;

    // Finished word: the assembled lower slices with the incoming last beat on top.
    always_comb begin
        packed_word = asm_reg;
        packed_word[TOP_LSB +: FE_WIDTH] = bus.i_fe_data;
    end

    // Beat counter: advances per accepted beat, wraps after the last one, cleared on abort.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (abort) begin
            cnt <= '0;
        end else if (accept) begin
            if (last_beat) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Assembly register: each accepted non-last beat lands in its slice; stale slices are overwritten before reuse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            asm_reg <= '0;
        end else if (accept && !last_beat) begin
            asm_reg[cnt * FE_WIDTH +: FE_WIDTH] <= bus.i_fe_data;
        end
    end

    // Output slot: loads on the last beat, empties on a push unless refilled on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_reg   <= '0;
            out_valid <= 1'b0;
        end else if (load_out) begin
            out_reg   <= packed_word;
            out_valid <= 1'b1;
        end else if (push) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.o_fe_ready  = fe_ready;
    assign bus.o_wr_en     = push;
    assign bus.o_wr_data   = out_reg;
    assign bus.o_beat_cnt  = cnt;
    assign bus.o_out_valid = out_valid;

endmodule

// File: tb/tb_write_data_packer.sv
// Self-checking bench for write_data_packer. A reference model built from
// lists of accepted beats predicts handshake state and finished words; words
// go into a scoreboard queue and a negedge monitor compares them with what
// the packer presents to the FIFO.
// Optional macro: WRITE_PACKER_ABORT_EN enables the abort scenario.

module tb_write_data_packer;

    localparam int FE    = 64;
    localparam int BEATS = 4;
    localparam int BE    = FE * BEATS;

    logic clk;
    logic rst_n;

    int tests_run    = 0;
    int tests_failed = 0;

    write_data_packer_if #(.FE_WIDTH(FE), .BEATS(BEATS)) bus ();

    write_data_packer #(.FE_WIDTH(FE), .BEATS(BEATS)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: beats collected so far, and whether a finished word awaits the FIFO.
    logic [FE-1:0] partial[$];
    logic [BE-1:0] exp_q[$];
    bit            model_slot_valid = 1'b0;
    bit            model_accepted   = 1'b0;
    bit            m_ready;
    bit            m_push;
    bit            m_accept;

    function automatic bit model_abort();
`ifdef WRITE_PACKER_ABORT_EN
        return bus.i_abort === 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_ready();
        bit slot_blocked;
        slot_blocked = (partial.size() == BEATS - 1) && model_slot_valid && bus.i_fifo_full;
        return !slot_blocked && !model_abort();
    endfunction

    function automatic logic [BE-1:0] pack_partial();
        logic [BE-1:0] w;
        w = '0;
        for (int i = 0; i < BEATS; i++) begin
            w[i*FE +: FE] = partial[i];
        end
        return w;
    endfunction

    task automatic check_output(input string name, input logic [BE-1:0] actual,
                                input logic [BE-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model update at each clock edge; reset empties everything, including words not yet pushed.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            partial.delete();
            exp_q.delete();
            model_slot_valid = 1'b0;
            model_accepted   = 1'b0;
        end else begin
            m_ready  = model_ready();
            m_accept = (bus.i_fe_valid === 1'b1) && m_ready;
            m_push   = model_slot_valid && (bus.i_fifo_full !== 1'b1);
            model_accepted = m_accept;
            if (model_abort()) begin
                partial.delete();
            end
            if (m_accept) begin
                partial.push_back(bus.i_fe_data);
            end
            if (partial.size() == BEATS) begin
                exp_q.push_back(pack_partial());
                partial.delete();
                model_slot_valid = 1'b1;
            end else if (m_push) begin
                model_slot_valid = 1'b0;
            end
        end
    end

    // Monitor: compares handshake state every cycle and the word offered to the FIFO.
    always @(negedge clk) begin
        check_output("fe_ready", BE'(bus.o_fe_ready), BE'(model_ready()));
        check_output("beat_cnt", BE'(bus.o_beat_cnt), BE'(partial.size()));
        check_output("out_valid", BE'(bus.o_out_valid), BE'(model_slot_valid));
        check_output("wr_en", BE'(bus.o_wr_en),
                     BE'(model_slot_valid && (bus.i_fifo_full !== 1'b1)));
        if (model_slot_valid) begin
            if (exp_q.size() == 0) begin
                check_output("scoreboard_word_missing", BE'(0), BE'(1));
            end else begin
                check_output("wr_data", bus.o_wr_data, exp_q[0]);
            end
        end
        if (bus.o_wr_en === 1'b1 && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
    end

    function automatic logic [FE-1:0] rand_beat();
        logic [FE-1:0] v;
        for (int i = 0; i < FE / 32; i++) begin
            v[i*32 +: 32] = $urandom();
        end
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one beat and waits (bounded) until the model sees it accepted.
    task automatic apply_stimulus(input logic [FE-1:0] data);
        int waited;
        waited = 0;
        bus.i_fe_valid = 1'b1;
        bus.i_fe_data  = data;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!model_accepted && waited < 200);
        if (!model_accepted) begin
            check_output("accept_timeout", BE'(0), BE'(1));
        end
        bus.i_fe_valid = 1'b0;
    endtask

    task automatic send_random(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(rand_beat());
            if (max_gap > 0) begin
                idle($urandom_range(0, max_gap));
            end
        end
    endtask

    task automatic apply_reset_and_check();
        rst_n = 1'b0;
        #1;
        check_output("rst_wr_en", BE'(bus.o_wr_en), BE'(0));
        check_output("rst_wr_data", bus.o_wr_data, BE'(0));
        check_output("rst_beat_cnt", BE'(bus.o_beat_cnt), BE'(0));
        check_output("rst_out_valid", BE'(bus.o_out_valid), BE'(0));
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        idle(1);
    endtask

    bit random_done;

    initial begin
        rst_n           = 1'b0;
        bus.i_fe_valid  = 1'b0;
        bus.i_fe_data   = '0;
        bus.i_fifo_full = 1'b0;
`ifdef WRITE_PACKER_ABORT_EN
        bus.i_abort     = 1'b0;
`endif
        apply_reset_and_check();

        // Fixed four-beat word, FIFO free.
        apply_stimulus({(FE/8){8'h11}});
        apply_stimulus({(FE/8){8'h22}});
        apply_stimulus({(FE/8){8'h33}});
        apply_stimulus({(FE/8){8'h44}});
        idle(3);

        // Sixteen back-to-back random beats.
        send_random(16, 0);
        idle(3);

        // FIFO full while streaming twelve beats, then released.
        bus.i_fifo_full = 1'b1;
        fork
            send_random(12, 0);
            begin
                idle(20);
                bus.i_fifo_full = 1'b0;
            end
        join
        idle(3);

        // Random valid gaps.
        send_random(12, 4);
        idle(3);

        // Random gaps together with a randomly toggling FIFO full.
        random_done = 1'b0;
        fork
            begin
                send_random(24, 2);
                random_done = 1'b1;
            end
            begin
                while (!random_done) begin
                    bus.i_fifo_full = ($urandom_range(0, 2) == 0);
                    idle(1);
                end
                bus.i_fifo_full = 1'b0;
            end
        join
        idle(3);

        // Reset in the middle of a word.
        send_random(2, 0);
        apply_reset_and_check();
        send_random(4, 0);
        idle(3);

        // Reset while a finished word waits behind a full FIFO.
        bus.i_fifo_full = 1'b1;
        send_random(4, 0);
        idle(2);
        apply_reset_and_check();
        bus.i_fifo_full = 1'b0;
        send_random(4, 0);
        idle(3);

`ifdef WRITE_PACKER_ABORT_EN
        // Abort drops a three-beat partial word.
        send_random(3, 0);
        bus.i_abort = 1'b1;
        idle(1);
        bus.i_abort = 1'b0;
        send_random(4, 0);
        idle(3);
`endif

        // Drain: every predicted word must have reached the FIFO.
        bus.i_fifo_full = 1'b0;
        idle(10);
        check_output("drain_empty", BE'(exp_q.size()), BE'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
